// File: rtl/pipe_pkg.sv
// pipe_pkg
// Shared definitions for the LEGv8 5-stage pipeline: opcode constants,
// the XZR register index, instruction field-slice helpers and the
// IF/ID register update selector.
package pipe_pkg;

  localparam int          REG_IDX_W  = 5;
  localparam logic [4:0]  ZERO_REG   = 5'd31;
  localparam logic [10:0] OP_STUR    = 11'h7C0;
  localparam logic [10:0] OP_LDUR    = 11'h7C2;
  localparam logic [7:0]  OP_CBZ_PFX = 8'hB4;

  // What the IF/ID register does on the coming edge (reset handled separately)
  typedef enum logic [1:0] {
    UPD_LOAD  = 2'd0,
    UPD_STALL = 2'd1,
    UPD_FLUSH = 2'd2
  } upd_e;

  function automatic logic [10:0] get_opcode(input logic [31:0] instr);
    return instr[31:21];
  endfunction

  function automatic logic [4:0] get_rm(input logic [31:0] instr);
    return instr[20:16];
  endfunction

  function automatic logic [4:0] get_rn(input logic [31:0] instr);
    return instr[9:5];
  endfunction

  function automatic logic [4:0] get_rt(input logic [31:0] instr);
    return instr[4:0];
  endfunction

  function automatic logic is_load(input logic [31:0] instr);
    return instr[31:21] == OP_LDUR;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// hazard_detect
// Purely combinational load-use compare. Takes the already-sliced fields
// of the instruction sitting in decode and the destination of the load
// sitting in ID/EX, and flags whether decode must wait one cycle.
// Ports:
//   valid     - decode slot holds a live instruction
//   mem_read  - ID/EX holds a load
//   rd        - ID/EX destination register
//   opcode    - decode instruction [31:21]
//   rn/rm/rt  - decode instruction source/target fields
//   hazard    - stall request
module hazard_detect
  import pipe_pkg::*;
#(
  parameter logic [4:0] ZERO_REG = pipe_pkg::ZERO_REG
) (
  input  logic        valid,
  input  logic        mem_read,
  input  logic [4:0]  rd,
  input  logic [10:0] opcode,
  input  logic [4:0]  rn,
  input  logic [4:0]  rm,
  input  logic [4:0]  rt,
  output logic        hazard
);

  logic uses_rt;
  logic src_match;

  // Stores and CBZ read Rt as a source; everything else is checked on Rn/Rm
  // regardless of format, which may stall needlessly but never misses.
  assign uses_rt   = (opcode == OP_STUR) || (opcode[10:3] == OP_CBZ_PFX);
  assign src_match = (rd == rn) || (rd == rm) || (uses_rt && (rd == rt));
  assign hazard    = valid && mem_read && (rd != ZERO_REG) && src_match;

endmodule

// File: rtl/reg_if_id_hazard.sv
// reg_if_id_hazard
// IF/ID pipeline register with load-use stall and taken-branch flush.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   pc_in, instr_in     - fetched PC and instruction
//   id_ex_mem_read      - ID/EX holds a load
//   id_ex_rd            - ID/EX destination register
//   branch_taken        - taken branch from EX/MEM, squashes this slot
//   pc_out, instr_out   - registered PC/instruction to decode
//   valid_out           - instr_out is live
//   pc_write            - PC enable, low freezes fetch during a stall
//   id_ex_bubble        - zero the ID/EX control fields
//   stall_cnt/flush_cnt - saturating performance counters
module reg_if_id_hazard
  import pipe_pkg::*;
#(
  parameter int         PC_W     = 64,
  parameter int         INSTR_W  = 32,
  parameter int         CNT_W    = 32,
  parameter logic [4:0] ZERO_REG = pipe_pkg::ZERO_REG
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PC_W-1:0]    pc_in,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               id_ex_mem_read,
  input  logic [4:0]         id_ex_rd,
  input  logic               branch_taken,
  output logic [PC_W-1:0]    pc_out,
  output logic [INSTR_W-1:0] instr_out,
  output logic               valid_out,
  output logic               pc_write,
  output logic               id_ex_bubble,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  logic hazard;
  upd_e upd;

  hazard_detect #(
    .ZERO_REG (ZERO_REG)
  ) u_hazard (
    .valid    (valid_out),
    .mem_read (id_ex_mem_read),
    .rd       (id_ex_rd),
    .opcode   (get_opcode(instr_out)),
    .rn       (get_rn(instr_out)),
    .rm       (get_rm(instr_out)),
    .rt       (get_rt(instr_out)),
    .hazard   (hazard)
  );

  // A taken branch discards the slot anyway, so it overrides a stall.
  always_comb begin
    upd = UPD_LOAD;
    if (branch_taken) begin
      upd = UPD_FLUSH;
    end else if (hazard) begin
      upd = UPD_STALL;
    end
  end

  // Both flush and stall need ID/EX to receive a bubble; only a stall
  // freezes fetch. Reset forces the idle values.
  assign pc_write     = reset || (upd != UPD_STALL);
  assign id_ex_bubble = !reset && (upd != UPD_LOAD);

  // Flush still captures pc_in/instr_in; the contents are dead because
  // valid_out drops. Counters stick at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_out    <= '0;
      instr_out <= '0;
      valid_out <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      unique case (upd)
        UPD_FLUSH: begin
          pc_out    <= pc_in;
          instr_out <= instr_in;
          valid_out <= 1'b0;
          if (!(&flush_cnt)) begin
            flush_cnt <= flush_cnt + CNT_W'(1);
          end
        end
        UPD_STALL: begin
          if (!(&stall_cnt)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
          end
        end
        default: begin
          pc_out    <= pc_in;
          instr_out <= instr_in;
          valid_out <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_if_id_hazard.sv
// tb_reg_if_id_hazard
// Scoreboard bench for reg_if_id_hazard: the driver updates a behavioural
// model and queues the expected outputs for each cycle; the monitor
// samples the DUT and compares against the queue.
module tb_reg_if_id_hazard;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] pcIn;
  logic [31:0] instrIn;
  logic        idExMemRead;
  logic [4:0]  idExRd;
  logic        branchTaken;
  logic [63:0] pcOut;
  logic [31:0] instrOut;
  logic        validOut;
  logic        pcWrite;
  logic        idExBubble;
  logic [31:0] stallCnt;
  logic [31:0] flushCnt;

  typedef struct packed {
    logic        pw;
    logic        bub;
    logic [63:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic [31:0] sc;
    logic [31:0] fc;
  } expT;

  expT expQ[$];

  // Model state: what decode should be holding
  logic [63:0] mPc;
  logic [31:0] mInstr;
  logic        mValid;
  logic [31:0] mStall;
  logic [31:0] mFlush;

  logic sPw;
  logic sBub;

  int errors = 0;
  int checks = 0;

  reg_if_id_hazard dut (
    .clk            (clk),
    .reset          (reset),
    .pc_in          (pcIn),
    .instr_in       (instrIn),
    .id_ex_mem_read (idExMemRead),
    .id_ex_rd       (idExRd),
    .branch_taken   (branchTaken),
    .pc_out         (pcOut),
    .instr_out      (instrOut),
    .valid_out      (validOut),
    .pc_write       (pcWrite),
    .id_ex_bubble   (idExBubble),
    .stall_cnt      (stallCnt),
    .flush_cnt      (flushCnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [10:0] op, input logic [4:0] rm,
                                     input logic [4:0] rn, input logic [4:0] rt);
    return {op, rm, 6'd0, rn, rt};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle of inputs (called at a negedge), advance the model by
  // the rules for this cycle and queue what the DUT must show.
  task automatic applyStimulus(input logic r, input logic [63:0] pc, input logic [31:0] ins,
                               input logic mr, input logic [4:0] rd, input logic br);
    int unsigned w, op, rn, rm, rt;
    bit usesRt, haz;
    expT e;
    reset = r; pcIn = pc; instrIn = ins; idExMemRead = mr; idExRd = rd; branchTaken = br;
    w  = mInstr;
    op = w >> 21;
    rm = (w >> 16) % 32;
    rn = (w >> 5) % 32;
    rt = w % 32;
    usesRt = (op == 'h7C0) || ((op / 8) == 'hB4);
    haz = mValid && mr && (rd != 31) && ((rd == rn) || (rd == rm) || (usesRt && (rd == rt)));
    if (r) begin
      e.pw = 1'b1; e.bub = 1'b0;
      mPc = '0; mInstr = '0; mValid = 1'b0; mStall = '0; mFlush = '0;
    end else begin
      e.pw  = !(haz && !br);
      e.bub = haz || br;
      if (br) begin
        mPc = pc; mInstr = ins; mValid = 1'b0;
        if (mFlush != 32'hFFFF_FFFF) mFlush = mFlush + 1;
      end else if (haz) begin
        if (mStall != 32'hFFFF_FFFF) mStall = mStall + 1;
      end else begin
        mPc = pc; mInstr = ins; mValid = 1'b1;
      end
    end
    e.pc = mPc; e.instr = mInstr; e.valid = mValid; e.sc = mStall; e.fc = mFlush;
    expQ.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: combinational outputs just after inputs settle, registered
  // outputs just after the following posedge.
  initial begin
    expT e;
    forever begin
      @(negedge clk);
      #2;
      sPw  = pcWrite;
      sBub = idExBubble;
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("pc_write",     64'(sPw),      64'(e.pw));
        checkOutput("id_ex_bubble", 64'(sBub),     64'(e.bub));
        checkOutput("pc_out",       pcOut,         e.pc);
        checkOutput("instr_out",    64'(instrOut), 64'(e.instr));
        checkOutput("valid_out",    64'(validOut), 64'(e.valid));
        checkOutput("stall_cnt",    64'(stallCnt), 64'(e.sc));
        checkOutput("flush_cnt",    64'(flushCnt), 64'(e.fc));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] addA, addXzr, stur5, add5, cbz7, rndIns;
    logic [10:0] op;
    logic [4:0]  rgs [3];
    int kind;
    mPc = '0; mInstr = '0; mValid = 1'b0; mStall = '0; mFlush = '0;
    reset = 1'b1; pcIn = '0; instrIn = '0; idExMemRead = 1'b0; idExRd = '0; branchTaken = 1'b0;
    addA   = mk(11'h458, 5'd3, 5'd2, 5'd1);
    addXzr = mk(11'h458, 5'd3, 5'd31, 5'd1);
    stur5  = mk(11'h7C0, 5'd0, 5'd9, 5'd5);
    add5   = mk(11'h458, 5'd7, 5'd6, 5'd5);
    cbz7   = {8'hB4, 24'd7};
    @(negedge clk);

    // Reset for two cycles, the second with a branch that must be ignored
    applyStimulus(1, 64'h40, 32'h8B02_0020, 0, 0, 0);
    applyStimulus(1, 64'h40, 32'h8B02_0020, 1, 0, 1);
    applyStimulus(0, 64'h40, 32'h8B02_0020, 0, 0, 0);

    // Load-use on Rn, one stall cycle, then advance
    applyStimulus(0, 64'h44, addA, 0, 0, 0);
    applyStimulus(0, 64'h48, 32'h8B05_0084, 1, 2, 0);
    applyStimulus(0, 64'h48, 32'h8B05_0084, 0, 0, 0);

    // XZR never hazards even when fields name it
    applyStimulus(0, 64'h4C, addXzr, 0, 0, 0);
    applyStimulus(0, 64'h50, addA, 1, 31, 0);

    // Store reads Rt; ADD's Rd is not a source
    applyStimulus(0, 64'h54, stur5, 0, 0, 0);
    applyStimulus(0, 64'h58, add5, 1, 5, 0);
    applyStimulus(0, 64'h58, add5, 0, 0, 0);
    applyStimulus(0, 64'h5C, cbz7, 1, 5, 0);
    applyStimulus(0, 64'h60, addA, 1, 7, 0);
    applyStimulus(0, 64'h60, addA, 0, 0, 0);

    // Flush beats stall; the squashed slot then cannot hazard
    applyStimulus(0, 64'h64, addA, 1, 2, 1);
    applyStimulus(0, 64'h68, addA, 1, 2, 0);

    // Reset during a stall, then a normal load
    applyStimulus(0, 64'h6C, addA, 1, 3, 0);
    applyStimulus(1, 64'h70, addA, 1, 3, 0);
    applyStimulus(0, 64'h74, addA, 1, 3, 0);

    // Saturation: preload stall_cnt to all-ones and stall twice
    applyStimulus(0, 64'h78, addA, 0, 0, 0);
    force dut.stall_cnt = 32'hFFFF_FFFF;
    mStall = 32'hFFFF_FFFF;
    applyStimulus(0, 64'h7C, addA, 1, 2, 0);
    release dut.stall_cnt;
    applyStimulus(0, 64'h7C, addA, 1, 3, 0);
    applyStimulus(0, 64'h7C, addA, 0, 0, 0);

    // Random traffic with a small register pool so collisions are common
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 3; k++) begin
        rgs[k] = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 5));
      end
      kind = $urandom_range(0, 4);
      case (kind)
        0: op = 11'h458;
        1: op = 11'h7C0;
        2: op = 11'h7C2;
        3: op = {8'hB4, 3'($urandom_range(0, 7))};
        default: op = 11'($urandom);
      endcase
      rndIns = mk(op, rgs[0], rgs[1], rgs[2]);
      applyStimulus(($urandom_range(0, 63) == 0), {$urandom, $urandom}, rndIns,
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 5)),
                    ($urandom_range(0, 7) == 0));
    end

    @(negedge clk);
    @(negedge clk);
    checkOutput("queue_drained", 64'(expQ.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
